// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multicycle ALU.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle (divider only with MULTICYCLE_ALU_DIV_EN).
// Latency: WIDTH cycles after start; done is high during the last step and res_nxt/hi_nxt carry the final values then.
// Backpressure: none; the owner must capture res_nxt/hi_nxt on the done cycle.
module alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_nxt,
  output logic [WIDTH-1:0] hi_nxt
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic             go;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;   // MUL: upper accumulator, DIV: partial remainder
  logic [WIDTH-1:0] lo_q;   // MUL: multiplier / low product, DIV: dividend / quotient
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

`ifdef MULTICYCLE_ALU_DIV_EN
  logic           div_q;
  logic [WIDTH:0] r2;
  assign go = start;
`else
  // Divider absent: a divide launch is refused so the core only multiplies.
  assign go = start && !is_div;
`endif

  // One iteration of the selected algorithm from the current register state.
  always_comb begin
    hi_step = hi_q;
    lo_step = lo_q;
    sum     = '0;
`ifdef MULTICYCLE_ALU_DIV_EN
    r2      = {hi_q, lo_q[WIDTH-1]};
    if (div_q) begin
      // Restoring step: shift in the next dividend bit, subtract if it fits.
      // b == 0 always "fits", giving an all-ones quotient and remainder == a.
      sum = r2 - {1'b0, b_q};
      if (r2 >= {1'b0, b_q}) begin
        hi_step = sum[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = r2[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      // Shift-add step: add b when the current multiplier bit is set, then shift right.
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done    = busy && (cnt == LAST);
  assign res_nxt = lo_step;
  assign hi_nxt  = hi_step;

  // Operand load on start, then one step per cycle until the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (go) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= a;
      b_q  <= b;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q <= is_div;
`endif
    end else if (busy) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/add ops, iterative MUL and (with MULTICYCLE_ALU_DIV_EN) DIV.
// Latency: out_valid 1 cycle after accept for ADD/SUB/logic, WIDTH+1 cycles for MUL/DIV.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);

  state_t           state;
  op_t              op_in;
  logic             accept;
  logic             is_div;
  logic             use_core;
  logic             dbz_pend;
  logic [WIDTH-1:0] alu_res;
  logic             core_done;
  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] core_hi;

  assign op_in    = op_t'(op);
  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_div   = (op_in == OP_DIV);
`ifdef MULTICYCLE_ALU_DIV_EN
  assign use_core = (op_in == OP_MUL) || is_div;
`else
  assign use_core = (op_in == OP_MUL);
`endif

  // Single-cycle results; DIV without the divider falls to the zero default.
  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && use_core),
    .is_div  (is_div),
    .a       (a),
    .b       (b),
    .done    (core_done),
    .res_nxt (core_res),
    .hi_nxt  (core_hi)
  );

  // Handshake FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      dbz_pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (use_core) begin
              state    <= CALC;
              dbz_pend <= is_div && (b == '0);
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= alu_res;
              hi          <= '0;
              zero        <= (alu_res == '0);
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          if (core_done) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= core_res;
            hi          <= core_hi;
            zero        <= (core_res == '0);
            div_by_zero <= dbz_pend;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32).
// Latency is counted with the accept edge as cycle 1.
// Covers reset, each op class, output hold under backpressure and mid-op reset.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .hi          (hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present one request, hold it through the accept edge, then scramble the operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 3'($urandom_range(0, 7));
  endtask

  // Called #1 after the accept edge; returns 1 if out_valid is already up.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (result !== 32'h0 || hi !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0/0", result, hi); end
    total++; if (zero !== 1'b0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", zero, div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_wrap;
    int lat;
    issue(3'd0, 32'hFFFF_FFFF, 32'h1);
    wait_valid(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
    total++; if (result !== 32'h0 || hi !== 32'h0) begin bad++; $display("FAIL add_res got=%h/%h exp=0/0", result, hi); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL add_zero got=%b exp=1", zero); end
    consume();
  endtask

  task automatic test_sub;
    int lat;
    issue(3'd1, 32'd5, 32'd7);
    wait_valid(lat);
    total++; if (lat != 1 || result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
      bad++; $display("FAIL sub got lat=%0d res=%h z=%b exp lat=1 res=fffffffe z=0", lat, result, zero);
    end
    consume();
  endtask

  task automatic test_logic;
    logic [2:0]  ops [3] = '{3'd4, 3'd5, 3'd7};
    logic [31:0] xa  [3] = '{32'hF0F0_F0F0, 32'h1234_0000, 32'h0F0F_0F0F};
    logic [31:0] xb  [3] = '{32'h3C3C_3C3C, 32'h0000_5678, 32'h00FF_00FF};
    logic [31:0] exp [3] = '{32'h3030_3030, 32'h1234_5678, 32'hF000_F000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], xa[i], xb[i]);
      wait_valid(lat);
      total++; if (lat != 1 || result !== exp[i] || hi !== 32'h0) begin
        bad++; $display("FAIL logic_%0d got lat=%0d res=%h hi=%h exp lat=1 res=%h hi=0", i, lat, result, hi, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_mul;
    int lat;
    issue(3'd2, 32'h0001_0000, 32'h0001_0000);
    wait_valid(lat);
    total++; if (lat != 33) begin bad++; $display("FAIL mul_lat got=%0d exp=33", lat); end
    total++; if (result !== 32'h0 || hi !== 32'h1 || zero !== 1'b1) begin
      bad++; $display("FAIL mul_pow got=%h/%h z=%b exp=0/1 z=1", result, hi, zero);
    end
    consume();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    total++; if (lat != 33 || result !== 32'h1 || hi !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mul_max got lat=%0d %h/%h exp lat=33 1/fffffffe", lat, result, hi);
    end
    consume();
    issue(3'd2, 32'd7, 32'd6);
    wait_valid(lat);
    total++; if (result !== 32'd42 || hi !== 32'h0) begin bad++; $display("FAIL mul_small got=%h/%h exp=2a/0", result, hi); end
    consume();
  endtask

  task automatic test_div;
    int lat;
    issue(3'd3, 32'd100, 32'd7);
    wait_valid(lat);
`ifdef MULTICYCLE_ALU_DIV_EN
    total++; if (lat != 33 || result !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL div got lat=%0d %h/%h dbz=%b exp lat=33 e/2 dbz=0", lat, result, hi, div_by_zero);
    end
`else
    total++; if (lat != 1 || result !== 32'd0 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL div got lat=%0d %h/%h dbz=%b exp lat=1 0/0 dbz=0", lat, result, hi, div_by_zero);
    end
`endif
    consume();
    issue(3'd3, 32'd5, 32'd0);
    wait_valid(lat);
`ifdef MULTICYCLE_ALU_DIV_EN
    total++; if (lat != 33 || result !== 32'hFFFF_FFFF || hi !== 32'd5 || div_by_zero !== 1'b1) begin
      bad++; $display("FAIL div0 got lat=%0d %h/%h dbz=%b exp lat=33 ffffffff/5 dbz=1", lat, result, hi, div_by_zero);
    end
`else
    total++; if (lat != 1 || result !== 32'd0 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL div0 got lat=%0d %h/%h dbz=%b exp lat=1 0/0 dbz=0", lat, result, hi, div_by_zero);
    end
`endif
    consume();
  endtask

  task automatic test_hold;
    int lat;
    issue(3'd6, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      op = 3'd0; a = 32'd1; b = 32'd1;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h5A5A_5A5A) begin
        bad++; $display("FAIL hold_%0d got v=%b rdy=%b res=%h exp v=1 rdy=0 res=5a5a5a5a", i, out_valid, in_ready, result);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_no_second got v=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || result !== 32'h0 || hi !== 32'h0 || zero !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL mid_rst got v=%b %h/%h z=%b dbz=%b exp all 0", out_valid, result, hi, zero, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_rdy got=%b exp=1", in_ready); end
    issue(3'd0, 32'd2, 32'd3);
    wait_valid(lat);
    total++; if (lat != 1 || result !== 32'd5 || zero !== 1'b0) begin
      bad++; $display("FAIL mid_rst_add got lat=%0d res=%h exp lat=1 res=5", lat, result);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_logic();
    test_mul();
    test_div();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
